// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset control unit.
// Covers FSM states, instruction classes, opcodes and datapath select codes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  typedef enum logic [1:0] {
    CL_ADDI,
    CL_ADD,
    CL_LW,
    CL_BR
  } instr_class_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic IMM_I = 1'b1;
  localparam logic IMM_B = 1'b0;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational IR field decode: instruction class, bne flag and legality.
// Pure logic, zero latency; no handshake.
module instr_class_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output instr_class_t cls,
  output logic         is_bne,
  output logic         legal
);

  always_comb begin
    cls    = CL_ADDI;
    is_bne = 1'b0;
    legal  = 1'b0;
    case (opcode)
      OP_IMM: begin
        cls   = CL_ADDI;
        legal = (funct3 == 3'b000);
      end
      OP_REG: begin
        cls   = CL_ADD;
        legal = (funct3 == 3'b000) && (funct7 == 7'b0000000);
      end
      OP_LOAD: begin
        cls   = CL_LW;
        legal = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        cls    = CL_BR;
        is_bne = (funct3 == 3'b001);
        legal  = (funct3 == 3'b000) || (funct3 == 3'b001);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: holds the IR and sequences PC/regfile/ALU/data memory.
// Branch 3 cycles, ALU ops 4, lw 5+ (MEM waits on mem_ready, traps after MEM_TIMEOUT).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  EQ,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  PCsrc,
  output logic                  IRWrite,
  output logic                  ImmSrc,
  output logic                  ALUsrc,
  output logic [2:0]            ALUctrl,
  output logic                  RegWrite,
  output logic                  ResultSrc,
  output logic                  mem_req,
  output logic                  halted,
  output logic [CNT_W-1:0]      retired
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

  state_t          state;
  logic [DATA_WIDTH-1:0] ir;
  logic [TW-1:0]   tcnt;
  instr_class_t    cls;
  logic            is_bne;
  logic            legal;

  // Register and immediate fields are consumed by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  instr_class_decode u_dec (
    .opcode (ir[6:0]),
    .funct3 (ir[14:12]),
    .funct7 (ir[31:25]),
    .cls    (cls),
    .is_bne (is_bne),
    .legal  (legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ir      <= '0;
      tcnt    <= '0;
      retired <= '0;
    end else begin
      if (PCWrite) retired <= retired + CNT_W'(1);
      if (IRWrite) ir <= instr;
      case (state)
        IDLE:   state <= FETCH;
        FETCH:  state <= DECODE;
        DECODE: state <= legal ? EXEC : TRAP;
        EXEC: begin
          tcnt <= '0;
          case (cls)
            CL_BR:   state <= FETCH;
            CL_LW:   state <= MEM;
            default: state <= WB;
          endcase
        end
        MEM: begin
          // A late mem_ready still completes the load on the final allowed cycle.
          if (mem_ready) begin
            state <= WB;
            tcnt  <= '0;
          end else if (tcnt == T_LAST) begin
            state <= TRAP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    IRWrite   = 1'b0;
    ImmSrc    = IMM_B;
    ALUsrc    = 1'b0;
    ALUctrl   = ALU_ADD;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    mem_req   = 1'b0;
    halted    = (state == TRAP);

    // ALU selects stay stable from EXEC through WB so the address/result holds.
    if (state == EXEC || state == MEM || state == WB) begin
      case (cls)
        CL_BR: begin
          ALUctrl = ALU_SUB;
          ALUsrc  = 1'b0;
          ImmSrc  = IMM_B;
        end
        CL_ADDI, CL_LW: begin
          ALUsrc = 1'b1;
          ImmSrc = IMM_I;
        end
        default: ALUsrc = 1'b0;
      endcase
    end

    case (state)
      FETCH: IRWrite = 1'b1;
      EXEC: begin
        if (cls == CL_BR) begin
          PCWrite = 1'b1;
          PCsrc   = EQ ^ is_bne;
        end
      end
      MEM: mem_req = 1'b1;
      WB: begin
        RegWrite  = 1'b1;
        ResultSrc = (cls == CL_LW);
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed cycle table plus randomized instruction streams
// checked against a per-instruction cycle-trace model built from the ISA subset rules.
module tb_multicycle_ctrl;

  localparam int T  = 16;
  localparam int CW = 4;

  // Expected-output bits: {PCWrite,PCsrc,IRWrite,ImmSrc,ALUsrc,ALUctrl[2:0],RegWrite,ResultSrc,mem_req,halted}
  localparam logic [11:0] PCW = 12'h800, PCS = 12'h400, IRW = 12'h200, IMM = 12'h100;
  localparam logic [11:0] ALS = 12'h080, SUB = 12'h010, RW  = 12'h008, RS  = 12'h004;
  localparam logic [11:0] MR  = 12'h002, HLT = 12'h001;
  localparam logic [11:0] ALL = 12'hFFF, NOALU = 12'hE0F, NOIMM = 12'hEFF;
  localparam logic [31:0] J   = 32'h0000007F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic EQ = 1'b0;
  logic mem_ready = 1'b0;
  logic PCWrite, PCsrc, IRWrite, ImmSrc, ALUsrc, RegWrite, ResultSrc, mem_req, halted;
  logic [2:0] ALUctrl;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(.DATA_WIDTH(32), .MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCsrc(PCsrc), .IRWrite(IRWrite), .ImmSrc(ImmSrc),
    .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .mem_req(mem_req), .halted(halted), .retired(retired)
  );

  typedef struct {
    logic        rst_n;
    logic [31:0] instr;
    logic        eq;
    logic        rdy;
    logic [11:0] exp;
    logic [11:0] mask;
  } vec_t;

  vec_t  tbl[$];
  vec_t  q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    model_ret = 0;
  int    step = 0;
  string tag = "init";

  function automatic vec_t mk(input logic r, input logic [31:0] w, input logic e,
                              input logic rd, input logic [11:0] x, input logic [11:0] m);
    vec_t v;
    v.rst_n = r; v.instr = w; v.eq = e; v.rdy = rd; v.exp = x; v.mask = m;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Legal encodings as mask/match pairs: 0 addi, 1 add, 2 lw, 3 beq, 4 bne, -1 illegal.
  function automatic int classify(input logic [31:0] w);
    logic [31:0] msk [5] = '{32'h0000707F, 32'hFE00707F, 32'h0000707F, 32'h0000707F, 32'h0000707F};
    logic [31:0] mat [5] = '{32'h00000013, 32'h00000033, 32'h00002003, 32'h00000063, 32'h00001063};
    for (int i = 0; i < 5; i++)
      if ((w & msk[i]) == mat[i]) return i;
    return -1;
  endfunction

  task automatic apply(input vec_t v);
    logic [11:0] act;
    @(negedge clk);
    rst_n = v.rst_n; instr = v.instr; EQ = v.eq; mem_ready = v.rdy;
    #1;
    act = {PCWrite, PCsrc, IRWrite, ImmSrc, ALUsrc, ALUctrl, RegWrite, ResultSrc, mem_req, halted};
    n_chk++;
    if ((act & v.mask) !== (v.exp & v.mask)) begin
      n_fail++;
      $display("FAIL %s step %0d outputs: got %h required %h (care %h)",
               tag, step, act & v.mask, v.exp & v.mask, v.mask);
    end
    n_chk++;
    if (retired !== CW'(model_ret)) begin
      n_fail++;
      $display("FAIL %s step %0d retired: got %0d required %0d", tag, step, retired, CW'(model_ret));
    end
    if (!v.rst_n) model_ret = 0;
    else if (v.exp[11]) model_ret++;
    step++;
  endtask

  task automatic run_q();
    while (q.size() > 0) apply(q.pop_front());
  endtask

  // Expected cycle trace for one instruction. lat = MEM cycle on which mem_ready rises,
  // rst_mem = MEM cycle on which reset is asserted (0 = never).
  task automatic gen(input logic [31:0] w, input logic eq, input int lat, input int rst_mem,
                     output logic trapped);
    int   c;
    logic imm;
    logic rdy;
    c = classify(w);
    trapped = 1'b0;
    q.push_back(mk(1'b1, w, rb(), rb(), IRW, ALL));
    q.push_back(mk(1'b1, $urandom, rb(), rb(), 12'h000, ALL));
    if (c < 0) begin
      q.push_back(mk(1'b1, $urandom, rb(), rb(), HLT, ALL));
      trapped = 1'b1;
      return;
    end
    if (c >= 3) begin
      q.push_back(mk(1'b1, $urandom, eq, rb(),
                     PCW | SUB | (((eq ^ (c == 4)) != 0) ? PCS : 12'h000), ALL));
      return;
    end
    imm = (c != 1);
    q.push_back(mk(1'b1, $urandom, rb(), rb(), imm ? (IMM | ALS) : 12'h000, imm ? ALL : NOIMM));
    if (c == 2) begin
      for (int k = 1; k <= T; k++) begin
        if (k == rst_mem) begin
          q.push_back(mk(1'b0, $urandom, rb(), rb(), MR | IMM | ALS, ALL));
          q.push_back(mk(1'b1, $urandom, rb(), rb(), 12'h000, ALL));
          return;
        end
        rdy = (k == lat);
        q.push_back(mk(1'b1, $urandom, rb(), rdy, MR | IMM | ALS, ALL));
        if (rdy) break;
      end
      if (lat > T) begin
        q.push_back(mk(1'b1, $urandom, rb(), rb(), HLT, ALL));
        trapped = 1'b1;
        return;
      end
    end
    q.push_back(mk(1'b1, $urandom, rb(), rb(), PCW | RW | ((c == 2) ? RS : 12'h000), NOALU));
  endtask

  // Trap is sticky: hold it, then recover with a one-cycle reset.
  task automatic trap_tail();
    q.push_back(mk(1'b1, 32'h00500093, rb(), rb(), HLT, ALL));
    q.push_back(mk(1'b1, $urandom, rb(), rb(), HLT, ALL));
    q.push_back(mk(1'b0, $urandom, rb(), rb(), HLT, ALL));
    q.push_back(mk(1'b1, $urandom, rb(), rb(), 12'h000, ALL));
  endtask

  initial begin
    logic        tr;
    logic [31:0] w;
    int          kind;

    // reset, addi, bne taken/not, beq taken, illegal -> trap -> reset
    tbl.push_back(mk(1'b0, J, 1'b0, 1'b0, 12'h000, ALL));
    tbl.push_back(mk(1'b1, J, 1'b0, 1'b0, 12'h000, ALL));
    tbl.push_back(mk(1'b1, 32'h00500093, 1'b0, 1'b1, IRW, ALL));
    tbl.push_back(mk(1'b1, J, 1'b1, 1'b1, 12'h000, ALL));
    tbl.push_back(mk(1'b1, J, 1'b1, 1'b1, IMM | ALS, ALL));
    tbl.push_back(mk(1'b1, J, 1'b1, 1'b1, PCW | RW, NOALU));
    tbl.push_back(mk(1'b1, 32'hFE009CE3, 1'b1, 1'b0, IRW, ALL));
    tbl.push_back(mk(1'b1, J, 1'b1, 1'b0, 12'h000, ALL));
    tbl.push_back(mk(1'b1, J, 1'b0, 1'b1, PCW | PCS | SUB, ALL));
    tbl.push_back(mk(1'b1, 32'hFE009CE3, 1'b0, 1'b0, IRW, ALL));
    tbl.push_back(mk(1'b1, J, 1'b0, 1'b0, 12'h000, ALL));
    tbl.push_back(mk(1'b1, J, 1'b1, 1'b0, PCW | SUB, ALL));
    tbl.push_back(mk(1'b1, 32'h00000063, 1'b0, 1'b0, IRW, ALL));
    tbl.push_back(mk(1'b1, J, 1'b0, 1'b0, 12'h000, ALL));
    tbl.push_back(mk(1'b1, J, 1'b1, 1'b0, PCW | PCS | SUB, ALL));
    tbl.push_back(mk(1'b1, 32'h0000007F, 1'b0, 1'b0, IRW, ALL));
    tbl.push_back(mk(1'b1, 32'h00500093, 1'b0, 1'b0, 12'h000, ALL));
    tbl.push_back(mk(1'b1, 32'h00500093, 1'b1, 1'b1, HLT, ALL));
    tbl.push_back(mk(1'b1, 32'h00500093, 1'b1, 1'b1, HLT, ALL));
    tbl.push_back(mk(1'b0, J, 1'b0, 1'b0, HLT, ALL));
    tbl.push_back(mk(1'b1, J, 1'b0, 1'b0, 12'h000, ALL));

    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    tag = "table";
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    tag = "random";
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1:    w = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h13};
        2:       w = {7'h00, 10'($urandom), 3'b000, 5'($urandom), 7'h33};
        3, 4:    w = {12'($urandom), 5'($urandom), 3'b010, 5'($urandom), 7'h03};
        5, 6:    w = {7'($urandom), 10'($urandom), 3'b000, 5'($urandom), 7'h63};
        7:       w = {7'($urandom), 10'($urandom), 3'b001, 5'($urandom), 7'h63};
        8:       w = {7'($urandom_range(1, 127)), 10'($urandom), 3'b000, 5'($urandom), 7'h33};
        default: w = $urandom;
      endcase
      gen(w, rb(), $urandom_range(1, T + 2), 0, tr);
      if (tr) trap_tail();
      run_q();
    end

    tag = "lw_ready3";
    gen(32'h0000A103, 1'b0, 3, 0, tr);
    run_q();
    tag = "lw_ready_last";
    gen(32'h0000A103, 1'b0, T, 0, tr);
    run_q();
    tag = "lw_timeout";
    gen(32'h0000A103, 1'b0, 1000, 0, tr);
    if (tr) trap_tail();
    run_q();
    tag = "rst_in_mem";
    gen(32'h0000A103, 1'b0, 1000, 2, tr);
    run_q();
    tag = "add_after_rst";
    gen(32'h002081B3, 1'b1, 0, 0, tr);
    gen(32'h00500093, 1'b0, 0, 0, tr);
    run_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
